// File: rtl/mrd_stage_sequencer_if.sv
// Handshake/status bundle between the mixed-radix DFT sequencer and its memory/butterfly datapath.
// err_timeout exists only when MRD_SEQ_WDOG_EN is defined.
interface mrd_stage_sequencer_if #(
    parameter int unsigned MAX_STAGES = 6
);
    logic                      sink_sop;
    logic [11:0]               sink_dftpts;
    logic                      sink_ongoing;
    logic                      rd_ongoing;
    logic                      wr_ongoing;
    logic                      source_ongoing;
    logic [1:0]                state;
    logic [11:0]               dftpts;
    logic [2:0]                current_stage;
    logic [2:0]                num_stages;
    logic [3*MAX_STAGES-1:0]   Nf;
    logic [29:0]               Nf_PFA;
    logic                      source_start;
    logic                      busy;
    logic                      err_factor;
    logic                      err_overrun;
`ifdef MRD_SEQ_WDOG_EN
    logic                      err_timeout;
`endif

    modport master (
        input  sink_sop, sink_dftpts, sink_ongoing, rd_ongoing, wr_ongoing, source_ongoing,
        output state, dftpts, current_stage, num_stages, Nf, Nf_PFA,
               source_start, busy, err_factor, err_overrun
`ifdef MRD_SEQ_WDOG_EN
        , output err_timeout
`endif
    );

    modport slave (
        output sink_sop, sink_dftpts, sink_ongoing, rd_ongoing, wr_ongoing, source_ongoing,
        input  state, dftpts, current_stage, num_stages, Nf, Nf_PFA,
               source_start, busy, err_factor, err_overrun
`ifdef MRD_SEQ_WDOG_EN
        , input err_timeout
`endif
    );
endinterface

// File: rtl/mrd_stage_sequencer.sv
// Mixed-radix DFT sequencer: factorises the frame size into radix-4/2/3/5 stages and walks the memory
// through SINK -> (READ -> WRITE) x stages -> SOURCE. Define MRD_SEQ_WDOG_EN for the per-phase watchdog.
module mrd_stage_sequencer #(
    parameter int unsigned MAX_STAGES = 6
`ifdef MRD_SEQ_WDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 8192
`endif
) (
    input logic                   clk,
    input logic                   rst,
    mrd_stage_sequencer_if.master seq_if
);
    localparam int unsigned NF_W  = 3 * MAX_STAGES;
    localparam int unsigned PFA_W = 10;

    // Low two bits of each encoding are the externally visible state code.
    typedef enum logic [2:0] {
        ST_SINK   = 3'b000,
        ST_READ   = 3'b001,
        ST_WRITE  = 3'b010,
        ST_SOURCE = 3'b011,
        ST_IDLE   = 3'b100
    } state_e;

    state_e            state_q, state_d;
    logic [11:0]       dftpts_q, dftpts_d;
    logic [11:0]       res_q, res_d;
    logic [2:0]        cur_q, cur_d;
    logic [2:0]        num_q, num_d;
    logic [NF_W-1:0]   nf_q, nf_d;
    logic [PFA_W-1:0]  n1_q, n1_d, n2_q, n2_d, n3_q, n3_d;
    logic              src_start_q, src_start_d;
    logic              busy_q, busy_d;
    logic              err_factor_q, err_factor_d;
    logic              err_overrun_q, err_overrun_d;
    logic              seen_q, seen_d;
    logic              fell_q, fell_d;

    logic              flag_c, fell_c, fell_any_c, done_c, bad_c;
    logic [2:0]        radix_c;
    logic [11:0]       res_div_c;

`ifdef MRD_SEQ_WDOG_EN
    localparam int unsigned CNT_W = 14;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_timeout_q, err_timeout_d;
`endif

    // One factorisation step on the residue, in radix priority order 4, 2, 3, 5.
    always_comb begin
        radix_c   = 3'd0;
        res_div_c = res_q;
        bad_c     = 1'b0;
        done_c    = (res_q == 12'd1);
        if (res_q == 12'd0) begin
            bad_c = 1'b1;
        end else if (done_c) begin
            radix_c = 3'd0;
        end else if (res_q[1:0] == 2'b00) begin
            radix_c   = 3'd4;
            res_div_c = res_q >> 2;
        end else if (!res_q[0]) begin
            radix_c   = 3'd2;
            res_div_c = res_q >> 1;
        end else if (res_q % 12'd3 == 12'd0) begin
            radix_c   = 3'd3;
            res_div_c = res_q / 12'd3;
        end else if (res_q % 12'd5 == 12'd0) begin
            radix_c   = 3'd5;
            res_div_c = res_q / 12'd5;
        end else begin
            bad_c = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        dftpts_d      = dftpts_q;
        res_d         = res_q;
        cur_d         = cur_q;
        num_d         = num_q;
        nf_d          = nf_q;
        n1_d          = n1_q;
        n2_d          = n2_q;
        n3_d          = n3_q;
        src_start_d   = 1'b0;
        err_factor_d  = err_factor_q;
        err_overrun_d = seq_if.sink_sop && (state_q[1:0] != 2'b00);

        // Status flag owned by the current phase; it only counts after being seen high.
        flag_c = 1'b0;
        case (state_q)
            ST_SINK:   flag_c = seq_if.sink_ongoing;
            ST_READ:   flag_c = seq_if.rd_ongoing;
            ST_WRITE:  flag_c = seq_if.wr_ongoing;
            ST_SOURCE: flag_c = seq_if.source_ongoing;
            default:   flag_c = 1'b0;
        endcase
        fell_c     = seen_q && !flag_c;
        fell_any_c = fell_q || fell_c;
        seen_d     = seen_q || flag_c;
        fell_d     = fell_any_c;

        case (state_q)
            ST_IDLE: begin
                if (seq_if.sink_sop) begin
                    state_d      = ST_SINK;
                    dftpts_d     = seq_if.sink_dftpts;
                    res_d        = seq_if.sink_dftpts;
                    cur_d        = 3'd0;
                    num_d        = 3'd0;
                    nf_d         = '0;
                    n1_d         = PFA_W'(1);
                    n2_d         = PFA_W'(1);
                    n3_d         = PFA_W'(1);
                    err_factor_d = 1'b0;
                end
            end
            ST_SINK: begin
                if (!done_c && !err_factor_q) begin
                    if (bad_c || num_q == 3'(MAX_STAGES)) begin
                        err_factor_d = 1'b1;
                    end else begin
                        res_d = res_div_c;
                        num_d = num_q + 3'd1;
                        for (int k = 0; k < MAX_STAGES; k++) begin
                            if (3'(k) == num_q) nf_d[3*k +: 3] = radix_c;
                        end
                        case (radix_c)
                            3'd4:    n1_d = {n1_q[PFA_W-3:0], 2'b00};
                            3'd2:    n1_d = {n1_q[PFA_W-2:0], 1'b0};
                            3'd3:    n2_d = PFA_W'(n2_q * 10'd3);
                            3'd5:    n3_d = PFA_W'(n3_q * 10'd5);
                            default: n1_d = n1_q;
                        endcase
                    end
                end
                // Leave only once both the sink write has ended and the factoriser has resolved.
                if (fell_any_c && err_factor_q) begin
                    state_d = ST_IDLE;
                end else if (fell_any_c && done_c) begin
                    state_d = ST_READ;
                    cur_d   = 3'd0;
                end
            end
            ST_READ: begin
                if (fell_c) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (fell_c) begin
                    if (4'(cur_q) + 4'd1 < 4'(num_q)) begin
                        cur_d   = cur_q + 3'd1;
                        state_d = ST_READ;
                    end else begin
                        state_d     = ST_SOURCE;
                        src_start_d = 1'b1;
                    end
                end
            end
            ST_SOURCE: begin
                if (fell_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef MRD_SEQ_WDOG_EN
        cnt_d         = cnt_q + CNT_W'(1);
        err_timeout_d = err_timeout_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (seq_if.sink_sop) err_timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            state_d       = ST_IDLE;
            src_start_d   = 1'b0;
            err_timeout_d = 1'b1;
        end
`endif

        busy_d = (state_d != ST_IDLE);
        if (state_d != state_q) begin
            seen_d = 1'b0;
            fell_d = 1'b0;
`ifdef MRD_SEQ_WDOG_EN
            cnt_d  = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dftpts_q      <= '0;
            res_q         <= '0;
            cur_q         <= '0;
            num_q         <= '0;
            nf_q          <= '0;
            n1_q          <= '0;
            n2_q          <= '0;
            n3_q          <= '0;
            src_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_factor_q  <= 1'b0;
            err_overrun_q <= 1'b0;
            seen_q        <= 1'b0;
            fell_q        <= 1'b0;
`ifdef MRD_SEQ_WDOG_EN
            cnt_q         <= '0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            dftpts_q      <= dftpts_d;
            res_q         <= res_d;
            cur_q         <= cur_d;
            num_q         <= num_d;
            nf_q          <= nf_d;
            n1_q          <= n1_d;
            n2_q          <= n2_d;
            n3_q          <= n3_d;
            src_start_q   <= src_start_d;
            busy_q        <= busy_d;
            err_factor_q  <= err_factor_d;
            err_overrun_q <= err_overrun_d;
            seen_q        <= seen_d;
            fell_q        <= fell_d;
`ifdef MRD_SEQ_WDOG_EN
            cnt_q         <= cnt_d;
            err_timeout_q <= err_timeout_d;
`endif
        end
    end

    assign seq_if.state         = state_q[1:0];
    assign seq_if.dftpts        = dftpts_q;
    assign seq_if.current_stage = cur_q;
    assign seq_if.num_stages    = num_q;
    assign seq_if.Nf            = nf_q;
    assign seq_if.Nf_PFA        = {n3_q, n2_q, n1_q};
    assign seq_if.source_start  = src_start_q;
    assign seq_if.busy          = busy_q;
    assign seq_if.err_factor    = err_factor_q;
    assign seq_if.err_overrun   = err_overrun_q;
`ifdef MRD_SEQ_WDOG_EN
    assign seq_if.err_timeout   = err_timeout_q;
`endif
endmodule
